tlb_lookup: RTL
===============

// Module: tlb_lookup
// PURPOSE
//  Fully-associative TLB: translates 32-bit virtual addresses to physical addresses for the core.
//  On a hit it returns the translation one cycle after the request.
//  On a miss it raises a one-cycle tlb_miss_detected pulse carrying miss_vaddr, stalls the requester,
//  and waits for a fill (fill_valid/fill_paddr) from the downstream miss handler.
//  It then installs the entry and returns the translation.
// PARAMETERS
//  ENTRIES   4   number of TLB entries (power of 2, >=2)
//  PO_W      12  page-offset width; VPN/PPN width = 32-PO_W
// PORTS
//  clk               in   1   clock, rising edge
//  reset             in   1   asynchronous, active-high reset
//  req_valid         in   1   lookup request; accepted only in a cycle with stall==0
//  req_vaddr         in   32  virtual address of the request
//  flush             in   1   invalidate all entries (single-cycle pulse)
//  resp_valid        out  1   1-cycle pulse; resp_paddr is valid
//  resp_paddr        out  32  translated physical address
//  resp_hit          out  1   1 = response came from a hit, 0 = from a fill
//  stall             out  1   registered; high while a miss is outstanding
//  tlb_miss_detected out  1   1-cycle pulse to the miss handler
//  miss_vaddr        out  32  missing virtual address; held stable while stall==1
//  fill_valid        in   1   fill strobe from the miss handler (its tlb_update)
//  fill_paddr        in   32  handler physical address; only bits [31:PO_W] are used
// BEHAVIOUR
//  Reset:
//   - all outputs 0; state=IDLE; every entry valid=0; victim ptr=0.
//   - Reset mid-miss drops the pending request; a later fill_valid is ignored.
//  Storage:
//   - Per entry: valid, vpn[31:PO_W], ppn[31:PO_W].
//   - Lookup is combinational on req_vaddr[31:PO_W]; hit = any valid entry with a matching vpn.
//   - At most one entry can match, because entries are only installed on a miss.
//  FSM states: IDLE and MISS. stall is 1 exactly while state==MISS.
//  IDLE, req_valid & hit, at the clock edge:
//   - resp_valid<=1, resp_hit<=1, resp_paddr<={ppn, req_vaddr[PO_W-1:0]}.
//   - Hit latency is 1 cycle; back-to-back hits run every cycle.
//  IDLE, req_valid & miss, at the clock edge:
//   - miss_vaddr<=req_vaddr; tlb_miss_detected<=1 for exactly one cycle; state<=MISS.
//   - The request is consumed; the requester need not hold it.
//  MISS:
//   - req_valid is ignored.
//   - On fill_valid: write the entry at the victim ptr: valid=1, vpn=miss_vaddr[31:PO_W], ppn=fill_paddr[31:PO_W].
//   - The write overwrites any previous entry at that slot.
//   - ptr<=(ptr+1) mod ENTRIES (FIFO/round-robin replacement, wraps from ENTRIES-1 to 0).
//   - resp_valid<=1, resp_hit<=0, resp_paddr<={fill_paddr[31:PO_W], miss_vaddr[PO_W-1:0]}; state<=IDLE.
//   - Miss-to-response latency = fill arrival + 1 cycle; there is no timeout.
//  fill_valid in IDLE is ignored: no write, no response.
//  resp_valid, resp_hit and tlb_miss_detected return to 0 in every cycle that has no event.
//  flush:
//   - Clears every valid bit at the edge; ptr is unchanged.
//   - A lookup in the same cycle as flush uses the pre-flush contents.
//   - Flush during MISS does not abort the miss.
//   - flush together with fill_valid: the clear happens first, then the install, so the filled entry ends valid.
// CONFIGURATION
//  TLB_STATS_EN defined:
//   - adds outputs hit_count[31:0] and miss_count[31:0].
//   - Both are saturating at 32'hFFFF_FFFF, reset to 0, and unaffected by flush.
//   - hit_count increments on each accepted hit; miss_count increments on each tlb_miss_detected.
//  TLB_STATS_EN not defined: the ports and counters are absent; all other behaviour is identical.
// TESTING
//  1. Cold miss:
//     - stimulus: after reset, req 0x0000_1234; handler fills 0x8000_1234 two cycles later.
//     - response: miss pulse with miss_vaddr=0x0000_1234; stall for 2 cycles; resp_paddr=0x8000_1234, resp_hit=0.
//  2. Hit:
//     - stimulus: after test 1, req 0x0000_1ABC.
//     - response: next cycle resp_valid=1, resp_hit=1, resp_paddr=0x8000_1ABC; no miss pulse.
//  3. Replacement wrap:
//     - stimulus: fill VPNs 1,2,3,4,5 (ENTRIES=4), then req VPN 1.
//     - response: VPN 1 misses again and ptr wraps to slot 0; VPN 5 still hits.
//  4. Flush:
//     - stimulus: flush after test 2, then req 0x0000_1000.
//     - response: miss; a same-cycle request issued with the flush still hits.
//  5. Reset mid-miss:
//     - stimulus: assert reset in MISS, then apply fill_valid.
//     - response: stall=0 and no resp_valid after reset; no entry is written.
//  6. Stray fill:
//     - stimulus: fill_valid in IDLE.
//     - response: no resp_valid and no entry change. With TLB_STATS_EN, the counts match the hits and misses issued.

Source files
------------

// File: rtl/tlb_lookup.sv
// tlb_lookup: fully-associative TLB with FIFO (round-robin) replacement.
// A hit answers one cycle after the request; a miss pulses tlb_miss_detected,
// stalls the requester and waits for the miss handler's fill.
// Optional feature macro: TLB_STATS_EN adds saturating hit_count/miss_count outputs.
module tlb_lookup #(
  parameter int ENTRIES = 4,
  parameter int PO_W    = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [31:0] req_vaddr,
  input  logic        flush,
  output logic        resp_valid,
  output logic [31:0] resp_paddr,
  output logic        resp_hit,
  output logic        stall,
  output logic        tlb_miss_detected,
  output logic [31:0] miss_vaddr,
  input  logic        fill_valid,
  input  logic [31:0] fill_paddr
`ifdef TLB_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int VPN_W = 32 - PO_W;
  localparam int PTR_W = $clog2(ENTRIES);

  typedef enum logic {IDLE, MISS} state_t;

  state_t             r_state;
  state_t             w_nextState;

  logic [ENTRIES-1:0] r_valid;
  logic [VPN_W-1:0]   r_vpn [ENTRIES];
  logic [VPN_W-1:0]   r_ppn [ENTRIES];
  logic [PTR_W-1:0]   r_ptr;

  logic               r_respValid;
  logic               r_respHit;
  logic [31:0]        r_respPaddr;
  logic               r_missPulse;
  logic [31:0]        r_missVaddr;

  logic               w_hit;
  logic [VPN_W-1:0]   w_hitPpn;
  logic               w_acceptHit;
  logic               w_acceptMiss;
  logic               w_fill;

  logic               w_respValidNext;
  logic               w_respHitNext;
  logic [31:0]        w_respPaddrNext;
  logic               w_missPulseNext;
  logic [31:0]        w_missVaddrNext;

  // The page-offset bits of the fill address carry no translation information.
  logic               w_unusedFillOffset;
  assign w_unusedFillOffset = ^fill_paddr[PO_W-1:0];

  assign w_acceptHit  = (r_state == IDLE) && req_valid && w_hit;
  assign w_acceptMiss = (r_state == IDLE) && req_valid && !w_hit;
  assign w_fill       = (r_state == MISS) && fill_valid;

  // Associative match of the request VPN; at most one entry can match, so OR-ing is safe.
  always_comb begin
    w_hit    = 1'b0;
    w_hitPpn = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (r_valid[i] && (r_vpn[i] == req_vaddr[31:PO_W])) begin
        w_hit    = 1'b1;
        w_hitPpn = w_hitPpn | r_ppn[i];
      end
    end
  end

  // State register: a reset drops any outstanding miss.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: enter MISS on a missing request, leave it when the fill arrives.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_acceptMiss) w_nextState = MISS;
      MISS:    if (fill_valid)   w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Output decode: compute the next values of the registered response and miss outputs.
  always_comb begin
    w_respValidNext = 1'b0;
    w_respHitNext   = 1'b0;
    w_respPaddrNext = r_respPaddr;
    w_missPulseNext = 1'b0;
    w_missVaddrNext = r_missVaddr;
    case (r_state)
      IDLE: begin
        if (w_acceptHit) begin
          w_respValidNext = 1'b1;
          w_respHitNext   = 1'b1;
          w_respPaddrNext = {w_hitPpn, req_vaddr[PO_W-1:0]};
        end else if (w_acceptMiss) begin
          w_missPulseNext = 1'b1;
          w_missVaddrNext = req_vaddr;
        end
      end
      MISS: begin
        if (fill_valid) begin
          w_respValidNext = 1'b1;
          w_respPaddrNext = {fill_paddr[31:PO_W], r_missVaddr[PO_W-1:0]};
        end
      end
      default: ;
    endcase
  end

  // Output registers so every response and miss signal comes straight from a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_respValid <= 1'b0;
      r_respHit   <= 1'b0;
      r_respPaddr <= '0;
      r_missPulse <= 1'b0;
      r_missVaddr <= '0;
    end else begin
      r_respValid <= w_respValidNext;
      r_respHit   <= w_respHitNext;
      r_respPaddr <= w_respPaddrNext;
      r_missPulse <= w_missPulseNext;
      r_missVaddr <= w_missVaddrNext;
    end
  end

  // Valid bits and victim pointer: flush clears first, so a same-edge fill still lands valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      r_ptr   <= '0;
    end else begin
      if (flush) begin
        r_valid <= '0;
      end
      if (w_fill) begin
        r_valid[r_ptr] <= 1'b1;
        r_ptr          <= r_ptr + 1'b1;
      end
    end
  end

  // Tag/data storage: only written on a fill, and only meaningful where the valid bit is set.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_vpn[r_ptr] <= r_missVaddr[31:PO_W];
      r_ppn[r_ptr] <= fill_paddr[31:PO_W];
    end
  end

  assign resp_valid        = r_respValid;
  assign resp_hit          = r_respHit;
  assign resp_paddr        = r_respPaddr;
  assign tlb_miss_detected = r_missPulse;
  assign miss_vaddr        = r_missVaddr;
  assign stall             = (r_state == MISS);

`ifdef TLB_STATS_EN
  logic [31:0] r_hitCount;
  logic [31:0] r_missCount;

  // Saturating statistics counters; flush leaves them alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hitCount  <= '0;
      r_missCount <= '0;
    end else begin
      if (w_acceptHit && (r_hitCount != 32'hFFFF_FFFF)) begin
        r_hitCount <= r_hitCount + 32'd1;
      end
      if (w_acceptMiss && (r_missCount != 32'hFFFF_FFFF)) begin
        r_missCount <= r_missCount + 32'd1;
      end
    end
  end

  assign hit_count  = r_hitCount;
  assign miss_count = r_missCount;
`endif

endmodule
